// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - SISC instruction-fetch stage: PC, IR and req/ack fetch FSM
//
// Optional feature macro: FETCH_TIMEOUT_EN (adds REQ wait counter, abort and sticky fetch_err).
//
// Ports:
//   clk, rst_f      clock, asynchronous active-low reset
//   pc_rst          synchronous PC clear (priority over pc_write)
//   pc_write        load next-PC into PC
//   pc_sel, br_sel  next-PC select: PC+1 / relative branch / absolute branch
//   ir_load         start fetch of the word at the current PC (ignored while busy)
//   im_req, im_addr instruction-memory request and address
//   im_ack, im_data instruction-memory data valid and word
//   pc_out, ir_out  current PC and IR
//   opcode, mm      IR fields [31:28] and [27:24]
//   fetch_busy      high while a fetch is outstanding
//   fetch_err       sticky fetch timeout flag (0 when FETCH_TIMEOUT_EN is undefined)
module fetch_unit #(
  parameter int PC_W    = 16,
  parameter int TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst_f,
  input  logic            pc_rst,
  input  logic            pc_write,
  input  logic            pc_sel,
  input  logic            br_sel,
  input  logic            ir_load,
  input  logic            im_ack,
  input  logic [31:0]     im_data,
  output logic            im_req,
  output logic [PC_W-1:0] im_addr,
  output logic [PC_W-1:0] pc_out,
  output logic [31:0]     ir_out,
  output logic [3:0]      opcode,
  output logic [3:0]      mm,
  output logic            fetch_busy,
  output logic            fetch_err
);

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

  state_t          state, state_nx;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] fetch_addr;
  logic [PC_W-1:0] pc_next;
  logic [31:0]     ir_q;
  logic [31:0]     rel_off;
  logic            ack_take;
  logic            abort;
  logic            to_hit;
  logic            busy;

  // A TIMEOUT below 2 leaves no usable wait window; the marker block makes such
  // a configuration visible in the elaborated hierarchy.
  if (TIMEOUT < 2) begin : g_timeout_below_minimum
  end

`ifdef FETCH_TIMEOUT_EN
  localparam int              CW      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0]   CNT_MAX = CW'(TIMEOUT - 1);

  logic [CW-1:0] wait_cnt;
  logic          err_q;

  assign to_hit = (wait_cnt == CNT_MAX);

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      // Held at zero in IDLE, so the count always starts from zero on REQ entry.
      if (state == IDLE) begin
        wait_cnt <= '0;
      end else if (!im_ack) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (abort) begin
        err_q <= 1'b1;
      end
    end
  end

  assign fetch_err = err_q;
`else
  assign to_hit    = 1'b0;
  assign fetch_err = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // FSM next-state and decode; ack takes precedence over a coincident timeout
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    ack_take = 1'b0;
    abort    = 1'b0;
    case (state)
      IDLE: begin
        if (ir_load) begin
          state_nx = REQ;
        end
      end
      REQ: begin
        busy = 1'b1;
        if (im_ack) begin
          ack_take = 1'b1;
          state_nx = IDLE;
        end else if (to_hit) begin
          abort    = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Relative offset is IR[15:0] sign-extended, then truncated to the PC width.
  assign rel_off = {{16{ir_q[15]}}, ir_q[15:0]};

  always_comb begin
    pc_next = pc_q + 1'b1;
    if (pc_sel) begin
      if (br_sel) begin
        pc_next = ir_q[PC_W-1:0];
      end else begin
        pc_next = pc_q + rel_off[PC_W-1:0];
      end
    end
  end

  // PC, IR and latched fetch address
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      pc_q       <= '0;
      ir_q       <= '0;
      fetch_addr <= '0;
    end else begin
      if (pc_rst) begin
        pc_q <= '0;
      end else if (pc_write) begin
        pc_q <= pc_next;
      end
      // Address is frozen for the whole fetch, so PC writes during REQ do not disturb it.
      if (state == IDLE && ir_load) begin
        fetch_addr <= pc_q;
      end
      if (ack_take) begin
        ir_q <= im_data;
      end else if (abort) begin
        ir_q <= 32'h0;
      end
    end
  end

  assign im_req     = busy;
  assign fetch_busy = busy;
  assign im_addr    = fetch_addr;
  assign pc_out     = pc_q;
  assign ir_out     = ir_q;
  assign opcode     = ir_q[31:28];
  assign mm         = ir_q[27:24];

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;

  logic        clk;
  logic        rst_f;
  logic        pc_rst, pc_write, pc_sel, br_sel, ir_load, im_ack;
  logic [31:0] im_data;
  logic        im_req;
  logic [15:0] im_addr, pc_out;
  logic [31:0] ir_out;
  logic [3:0]  opcode, mm;
  logic        fetch_busy, fetch_err;

  int n_vec;
  int n_bad;

  fetch_unit #(.PC_W(16), .TIMEOUT(15)) dut (
    .clk        (clk),
    .rst_f      (rst_f),
    .pc_rst     (pc_rst),
    .pc_write   (pc_write),
    .pc_sel     (pc_sel),
    .br_sel     (br_sel),
    .ir_load    (ir_load),
    .im_ack     (im_ack),
    .im_data    (im_data),
    .im_req     (im_req),
    .im_addr    (im_addr),
    .pc_out     (pc_out),
    .ir_out     (ir_out),
    .opcode     (opcode),
    .mm         (mm),
    .fetch_busy (fetch_busy),
    .fetch_err  (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst, wr, sel, br, ld, ack;
    logic [31:0] data;
    logic [15:0] e_pc;
    logic [31:0] e_ir;
    logic        e_req;
    logic [15:0] e_addr;
  } vec_t;

  vec_t vecs[23];

  function automatic vec_t mk(logic rst, logic wr, logic sel, logic br, logic ld, logic ack,
                              logic [31:0] data, logic [15:0] e_pc, logic [31:0] e_ir,
                              logic e_req, logic [15:0] e_addr);
    vec_t v;
    v.rst = rst; v.wr = wr; v.sel = sel; v.br = br; v.ld = ld; v.ack = ack;
    v.data = data; v.e_pc = e_pc; v.e_ir = e_ir; v.e_req = e_req; v.e_addr = e_addr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive at the falling edge, then sample 1 time unit after the rising edge.
  task automatic step(input logic rst, input logic wr, input logic sel, input logic br,
                      input logic ld, input logic ack, input logic [31:0] data);
    @(negedge clk);
    pc_rst = rst; pc_write = wr; pc_sel = sel; br_sel = br;
    ir_load = ld; im_ack = ack; im_data = data;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_f = 1'b0;
    pc_rst = 0; pc_write = 0; pc_sel = 0; br_sel = 0; ir_load = 0; im_ack = 0; im_data = 0;
    @(negedge clk);
    rst_f = 1'b1;
  endtask

  // Fetch whose ack arrives at the k-th edge after the ir_load edge (k=1 is zero-wait).
  task automatic fetch_k(input int k, input logic [31:0] data, input string name);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    for (int i = 1; i < k; i++) begin
      idle_step();
      chk({name, "_req_wait"}, 32'(im_req), 32'h1);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, data);
    chk({name, "_ir"}, ir_out, data);
    chk({name, "_req_done"}, 32'(im_req), 32'h0);
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst_f = 1'b0;
    pc_rst = 0; pc_write = 0; pc_sel = 0; br_sel = 0; ir_load = 0; im_ack = 0; im_data = 0;

    //        rst wr sel br ld ack data           e_pc      e_ir          req addr
    vecs[0]  = mk(0, 0, 0, 0, 1, 0, 32'h0,         16'h0000, 32'h0000_0000, 1, 16'h0000);
    vecs[1]  = mk(0, 0, 0, 0, 0, 1, 32'h8000_1234, 16'h0000, 32'h8000_1234, 0, 16'h0000);
    vecs[2]  = mk(0, 1, 0, 0, 0, 0, 32'h0,         16'h0001, 32'h8000_1234, 0, 16'h0000);
    vecs[3]  = mk(0, 0, 0, 0, 1, 0, 32'h0,         16'h0001, 32'h8000_1234, 1, 16'h0001);
    vecs[4]  = mk(0, 1, 0, 0, 0, 0, 32'h0,         16'h0002, 32'h8000_1234, 1, 16'h0001);
    vecs[5]  = mk(0, 0, 0, 0, 1, 0, 32'h0,         16'h0002, 32'h8000_1234, 1, 16'h0001);
    vecs[6]  = mk(0, 0, 0, 0, 0, 0, 32'h0,         16'h0002, 32'h8000_1234, 1, 16'h0001);
    vecs[7]  = mk(0, 0, 0, 0, 0, 1, 32'h1000_0010, 16'h0002, 32'h1000_0010, 0, 16'h0001);
    vecs[8]  = mk(0, 1, 1, 1, 0, 0, 32'h0,         16'h0010, 32'h1000_0010, 0, 16'h0001);
    vecs[9]  = mk(0, 0, 0, 0, 1, 0, 32'h0,         16'h0010, 32'h1000_0010, 1, 16'h0010);
    vecs[10] = mk(0, 0, 0, 0, 0, 1, 32'h5A00_FFFE, 16'h0010, 32'h5A00_FFFE, 0, 16'h0010);
    vecs[11] = mk(0, 1, 1, 0, 0, 0, 32'h0,         16'h000E, 32'h5A00_FFFE, 0, 16'h0010);
    vecs[12] = mk(0, 0, 0, 0, 1, 0, 32'h0,         16'h000E, 32'h5A00_FFFE, 1, 16'h000E);
    vecs[13] = mk(0, 0, 0, 0, 0, 1, 32'h2300_0040, 16'h000E, 32'h2300_0040, 0, 16'h000E);
    vecs[14] = mk(0, 1, 1, 1, 0, 0, 32'h0,         16'h0040, 32'h2300_0040, 0, 16'h000E);
    vecs[15] = mk(1, 1, 0, 0, 0, 0, 32'h0,         16'h0000, 32'h2300_0040, 0, 16'h000E);
    vecs[16] = mk(0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF, 16'h0000, 32'h2300_0040, 0, 16'h000E);
    vecs[17] = mk(0, 0, 0, 0, 1, 0, 32'h0,         16'h0000, 32'h2300_0040, 1, 16'h0000);
    vecs[18] = mk(0, 0, 0, 0, 0, 1, 32'hF00F_FFFF, 16'h0000, 32'hF00F_FFFF, 0, 16'h0000);
    vecs[19] = mk(0, 1, 1, 1, 0, 0, 32'h0,         16'hFFFF, 32'hF00F_FFFF, 0, 16'h0000);
    vecs[20] = mk(0, 1, 0, 0, 0, 0, 32'h0,         16'h0000, 32'hF00F_FFFF, 0, 16'h0000);
    vecs[21] = mk(0, 1, 1, 0, 0, 0, 32'h0,         16'hFFFF, 32'hF00F_FFFF, 0, 16'h0000);
    vecs[22] = mk(1, 0, 0, 0, 0, 0, 32'h0,         16'h0000, 32'hF00F_FFFF, 0, 16'h0000);

    // Reset state, sampled while rst_f is held low
    repeat (2) @(negedge clk);
    chk("rst_pc", 32'(pc_out), 32'h0);
    chk("rst_ir", ir_out, 32'h0);
    chk("rst_req", 32'(im_req), 32'h0);
    chk("rst_addr", 32'(im_addr), 32'h0);
    chk("rst_busy", 32'(fetch_busy), 32'h0);
    chk("rst_err", 32'(fetch_err), 32'h0);
    chk("rst_opmm", {24'h0, opcode, mm}, 32'h0);
    rst_f = 1'b1;

    for (int i = 0; i < 23; i++) begin
      step(vecs[i].rst, vecs[i].wr, vecs[i].sel, vecs[i].br, vecs[i].ld, vecs[i].ack, vecs[i].data);
      chk($sformatf("v%0d_pc", i), 32'(pc_out), 32'(vecs[i].e_pc));
      chk($sformatf("v%0d_ir", i), ir_out, vecs[i].e_ir);
      chk($sformatf("v%0d_req", i), 32'(im_req), 32'(vecs[i].e_req));
      chk($sformatf("v%0d_busy", i), 32'(fetch_busy), 32'(vecs[i].e_req));
      chk($sformatf("v%0d_addr", i), 32'(im_addr), 32'(vecs[i].e_addr));
      chk($sformatf("v%0d_opcode", i), 32'(opcode), 32'(vecs[i].e_ir[31:28]));
      chk($sformatf("v%0d_mm", i), 32'(mm), 32'(vecs[i].e_ir[27:24]));
      chk($sformatf("v%0d_err", i), 32'(fetch_err), 32'h0);
    end

    // Asynchronous reset in the middle of a fetch
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("pre_arst_pc", 32'(pc_out), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("pre_arst_req", 32'(im_req), 32'h1);
    chk("pre_arst_addr", 32'(im_addr), 32'h1);
    ir_load = 1'b0;
    #2;
    rst_f = 1'b0;
    #1;
    chk("arst_req", 32'(im_req), 32'h0);
    chk("arst_busy", 32'(fetch_busy), 32'h0);
    chk("arst_pc", 32'(pc_out), 32'h0);
    chk("arst_ir", ir_out, 32'h0);
    chk("arst_addr", 32'(im_addr), 32'h0);
    chk("arst_opmm", {24'h0, opcode, mm}, 32'h0);
    @(negedge clk);
    rst_f = 1'b1;

    // Zero-wait and multi-wait fetches after reset
    fetch_k(1, 32'h7E00_0001, "zw");
    fetch_k(4, 32'h3300_0002, "w3");

`ifdef FETCH_TIMEOUT_EN
    // No ack: still requesting after 14 edges, aborted at the 15th
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    for (int i = 1; i < 15; i++) begin
      idle_step();
      chk("to_req_hold", 32'(im_req), 32'h1);
    end
    idle_step();
    chk("to_req_drop", 32'(im_req), 32'h0);
    chk("to_ir_noop", ir_out, 32'h0);
    chk("to_err_set", 32'(fetch_err), 32'h1);
    fetch_k(1, 32'h4444_0004, "post_to");
    chk("to_err_sticky", 32'(fetch_err), 32'h1);
    do_reset();
    chk("to_err_clr", 32'(fetch_err), 32'h0);
    fetch_k(14, 32'h5555_0005, "ack14");
    chk("ack14_err", 32'(fetch_err), 32'h0);
    fetch_k(15, 32'h6666_0006, "ack15");
    chk("ack15_err", 32'(fetch_err), 32'h0);
`else
    // Without the timeout the request waits indefinitely
    fetch_k(101, 32'h9999_0009, "late");
    chk("late_err", 32'(fetch_err), 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the SISC datapath: holds the program counter (PC) and instruction register (IR), fetches instruction words from instruction memory over a req/ack handshake, and computes sequential and branch next-PC values. It sits directly upstream of the control FSM. It supplies `opcode` and `mm` from the IR to the control FSM and accepts `pc_rst`, `pc_write`, `pc_sel`, `br_sel` and `ir_load` from it.

## Interface
- `PC_W`, 16: PC and instruction-memory address width.
- `TIMEOUT`, 15: maximum cycles in REQ without `im_ack` before abort (only with `FETCH_TIMEOUT_EN`; must be ≥ 2).
- `clk` input 1: clock; all state updates on the rising edge.
- `rst_f` input 1: reset, asynchronous, active-low.
- `pc_rst` input 1: synchronous PC clear.
- `pc_write` input 1: load next-PC into PC.
- `pc_sel` input 1: 0 = PC+1, 1 = branch target.
- `br_sel` input 1: 0 = relative target, 1 = absolute target.
- `ir_load` input 1: start fetch of the word at the current PC.
- `im_ack` input 1: memory data valid.
- `im_data` input 32: instruction word.
- `im_req` output 1: fetch request.
- `im_addr` output PC_W: fetch address.
- `pc_out` output PC_W: current PC.
- `ir_out` output 32: current IR.
- `opcode` output 4: `ir_out[31:28]`, combinational.
- `mm` output 4: `ir_out[27:24]`, combinational.
- `fetch_busy` output 1: high while in REQ.
- `fetch_err` output 1: sticky timeout flag.

## Operation
- FSM states:
  - IDLE → REQ on `ir_load`=1.
  - REQ → IDLE on `im_ack`=1 or on timeout.
  - No other states.
- **Entering REQ:** `fetch_addr` latches `pc_out`. `im_addr` = `fetch_addr` throughout REQ. `im_req` = 1 exactly while in REQ.
- **Completion:** in REQ with `im_ack`=1 at a rising edge, IR ← `im_data` and the FSM returns to IDLE. `im_req` falls on the following cycle.
- **Ignored inputs:** `ir_load` is ignored in REQ. `im_ack` is ignored in IDLE.
- **PC update (any state):**
  - `pc_rst`=1 → PC ← 0. This has priority over `pc_write`.
  - Otherwise `pc_write`=1 → PC ← next-PC.
  - Changing the PC during REQ does not affect `im_addr`.
- **Next-PC:**
  - `pc_sel`=0: PC+1.
  - `pc_sel`=1, `br_sel`=1: `ir_out[PC_W-1:0]`.
  - `pc_sel`=1, `br_sel`=0: PC + sign-extended `ir_out[15:0]`, truncated to PC_W.
  - All arithmetic is modulo 2^PC_W. PC+1 from all-ones wraps to 0.
- **Timeout** (with `FETCH_TIMEOUT_EN`):
  - A wait counter clears on entry to REQ and increments each REQ cycle without ack.
  - If the counter reaches `TIMEOUT`-1 with no ack: IR ← 32'h0 (NOOP), `fetch_err` ← 1, FSM → IDLE.
  - If ack and timeout coincide, ack wins (normal load, no error).
  - `fetch_err` clears only on reset.
- **Reset** (`rst_f`=0, asynchronous, including mid-fetch):
  - PC = 0, IR = 0, FSM = IDLE, `im_req` = 0, `im_addr` = 0, `fetch_addr` = 0, counter = 0, `fetch_err` = 0, `fetch_busy` = 0.
  - `opcode` and `mm` are therefore 0.

## Timing
- `ir_load` sampled at edge N → `im_req` high from N until the ack edge.
- Zero-wait memory (`im_ack` high in the first REQ cycle) → IR updated at edge N+1, `opcode`/`mm` valid after N+1.
- Ack after k wait cycles → IR updated at edge N+1+k.
- PC update latency: one edge after `pc_write`/`pc_rst`.
- Timeout abort occurs at edge N+`TIMEOUT`.
- `opcode`, `mm`, `pc_out` and `ir_out` are register outputs. `fetch_busy` is decoded from state only, not from inputs.

## Configuration
- `FETCH_TIMEOUT_EN` defined: wait counter and `fetch_err` are present, with abort behaviour as above.
- `FETCH_TIMEOUT_EN` undefined:
  - No counter; REQ waits indefinitely for `im_ack`.
  - `fetch_err` is tied to 0.
  - `TIMEOUT` is unused.

## Test plan
- **Sequential fetch:** reset, then `ir_load` with zero-wait memory returning 32'h8000_1234 → IR = 32'h8000_1234, `opcode`=8, `mm`=0, `im_addr`=0; then `pc_write`, `pc_sel`=0 → PC = 1.
- **Wait states:** `im_ack` delayed 3 cycles → `im_req` and `fetch_busy` high for 4 cycles. A `pc_write` during the wait changes PC but leaves `im_addr` constant. An `ir_load` pulse during the wait is ignored.
- **Branches:**
  - PC = 16'h0010, IR[15:0] = 16'hFFFE, `pc_sel`=1, `br_sel`=0 → PC = 16'h000E.
  - `br_sel`=1, IR[15:0] = 16'h0040 → PC = 16'h0040.
  - PC = 16'hFFFF with `pc_sel`=0 → PC = 0.
- **Priority and async reset:** `pc_rst` and `pc_write` both asserted → PC = 0. Asserting `rst_f`=0 mid-REQ drops `im_req` immediately (without waiting for a clock edge) and returns all outputs to their reset values.
- **Timeout** (`FETCH_TIMEOUT_EN`, `TIMEOUT`=15):
  - No ack → at edge N+15, IR = 0, `fetch_err` = 1, FSM = IDLE. `fetch_err` stays 1 through later good fetches until reset.
  - Ack on cycle 14 → normal load, `fetch_err` = 0.
- **No-timeout build** (`FETCH_TIMEOUT_EN` undefined): ack withheld for 100 cycles → `im_req` held high throughout, then the late ack loads IR; `fetch_err` = 0.
